// File: rtl/arb_grant_mux_pkg.sv
// arb_pkg: shared client-index type and a lowest-set-bit helper
// used by the grant mux and by the arbiter-side benches.  Rev 1.0
`default_nettype none

package arb_pkg;

  localparam int CLIENTS_DEF = 32;

  typedef logic [$clog2(CLIENTS_DEF)-1:0] client_idx_t;

  function automatic client_idx_t onehot_lowest_idx(input logic [CLIENTS_DEF-1:0] g);
    onehot_lowest_idx = '0;
    for (int i = CLIENTS_DEF - 1; i >= 0; i--) begin
      if (g[i]) onehot_lowest_idx = client_idx_t'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_grant_mux_if.sv
// arb_grant_mux_if: grant/payload inputs and valid/ready output of the grant mux.
// Rev 1.0
`default_nettype none

interface arb_grant_mux_if #(
  parameter int CLIENTS = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
);
  logic [CLIENTS-1:0]        grant;
  logic [CLIENTS*DATA_W-1:0] client_data;
  logic                      stall;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_client;
  logic                      grant_err;

  modport master (
    output grant, client_data, out_ready,
    input  stall, out_valid, out_data, out_client, grant_err
  );

  modport slave (
    input  grant, client_data, out_ready,
    output stall, out_valid, out_data, out_client, grant_err
  );
endinterface

`default_nettype wire

// File: rtl/arb_grant_mux_enc.sv
// arb_onehot_enc: combinational lowest-set-bit encoder, grant -> {idx, any}.
// Rev 1.0
`default_nettype none

module arb_onehot_enc #(
  parameter int CLIENTS = 32,
  parameter int IDX_W   = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  wire logic [CLIENTS-1:0] i_grant,
  output logic      [IDX_W-1:0]   o_idx,
  output logic                    o_any
);

  // Scanning downward lets the lowest set bit win on a multi-hot grant.
  always_comb begin
    o_idx = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (i_grant[i]) o_idx = IDX_W'(i);
    end
    o_any = |i_grant;
  end

endmodule

`default_nettype wire

// File: rtl/arb_grant_mux.sv
// arb_grant_mux: payload mux + 2-entry skid buffer behind the round-robin arbiter.
// Optional multi-hot grant checker: ARB_GRANT_MUX_ONEHOT_CHK_EN.  Rev 1.0
`default_nettype none

module arb_grant_mux
  import arb_pkg::*;
#(
  parameter int CLIENTS = CLIENTS_DEF,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input wire logic      clk,
  input wire logic      rst,
  arb_grant_mux_if.slave bus
);

  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_accept;
  logic              w_pop;

  logic              r_main_v;
  logic [DATA_W-1:0] r_main_data;
  logic [IDX_W-1:0]  r_main_idx;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_skid_data;
  logic [IDX_W-1:0]  r_skid_idx;

  arb_onehot_enc #(
    .CLIENTS (CLIENTS),
    .IDX_W   (IDX_W)
  ) u_enc (
    .i_grant (bus.grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel_data = bus.client_data[int'(w_idx) * DATA_W +: DATA_W];
  assign w_accept   = w_any && !r_skid_v;
  assign w_pop      = r_main_v && bus.out_ready;

  // Accept is blocked while the skid entry is full, so skid drain and accept never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_v    <= 1'b0;
      r_main_data <= '0;
      r_main_idx  <= '0;
      r_skid_v    <= 1'b0;
      r_skid_data <= '0;
      r_skid_idx  <= '0;
    end else if (r_skid_v) begin
      if (w_pop) begin
        r_main_data <= r_skid_data;
        r_main_idx  <= r_skid_idx;
        r_skid_v    <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_v || w_pop) begin
        r_main_v    <= 1'b1;
        r_main_data <= w_sel_data;
        r_main_idx  <= w_idx;
      end else begin
        r_skid_v    <= 1'b1;
        r_skid_data <= w_sel_data;
        r_skid_idx  <= w_idx;
      end
    end else if (w_pop) begin
      r_main_v <= 1'b0;
    end
  end

  assign bus.stall      = r_skid_v;
  assign bus.out_valid  = r_main_v;
  assign bus.out_data   = r_main_data;
  assign bus.out_client = r_main_idx;

`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
  logic w_multi;
  logic r_grant_err;

  assign w_multi = |(bus.grant & (bus.grant - CLIENTS'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_grant_err <= 1'b0;
    else     r_grant_err <= r_grant_err | w_multi;
  end

  assign bus.grant_err = r_grant_err;
`else
  assign bus.grant_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_grant_mux.sv
// tb_arb_grant_mux: directed stimulus with a queue model of the skid buffer.
// Rev 1.0
`default_nettype none

module tb_arb_grant_mux;
  import arb_pkg::*;

  localparam int CLIENTS = 32;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 5;
`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_grant_mux_if #(.CLIENTS(CLIENTS), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  arb_grant_mux #(.CLIENTS(CLIENTS), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } item_t;

  item_t q[$];
  bit    m_err = 1'b0;

  function automatic logic [31:0] payload(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic int lowest(input logic [CLIENTS-1:0] g);
    for (int i = 0; i < CLIENTS; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the buffer is a FIFO of depth 2; stall means it holds two items.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      automatic bit acc = (bus.grant != '0) && (q.size() < 2);
      automatic bit pop = (q.size() > 0) && bus.out_ready;
      automatic int li  = lowest(bus.grant);
      if (CHK_EN && $countones(bus.grant) > 1) m_err = 1'b1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{li, payload(li)});
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("stall", 64'(bus.stall), 64'(q.size() == 2));
      chk("grant_err", 64'(bus.grant_err), 64'(m_err));
      if (q.size() > 0) begin
        chk("client", 64'(bus.out_client), 64'(q[0].idx));
        chk("data", 64'(bus.out_data), 64'(q[0].data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.grant = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < CLIENTS; i++) bus.client_data[i*DATA_W +: DATA_W] = payload(i);

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_err", 64'(bus.grant_err), 64'd0);
    #1 rst = 1'b0;

    // Single transfer
    @(negedge clk); #1;
    bus.grant = 32'h1 << 5; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_client", 64'(bus.out_client), 64'd5);
    chk("single_data", 64'(bus.out_data), 64'hA5A5_0005);
    #1 bus.grant = '0;

    // Back-to-back, no bubble
    @(negedge clk); #1 bus.grant = 32'h1 << 3;
    @(negedge clk); chk("b2b_3", 64'(bus.out_client), 64'd3);
    chk("b2b_stall", 64'(bus.stall), 64'd0);
    #1 bus.grant = 32'h1 << 7;
    @(negedge clk); chk("b2b_7", 64'(bus.out_client), 64'd7);
    chk("b2b_valid", 64'(bus.out_valid), 64'd1);
    #1 bus.grant = 32'h1 << 9;
    @(negedge clk); chk("b2b_9", 64'(bus.out_client), 64'd9);
    #1 bus.grant = '0;

    // Backpressure: fill main and skid, third grant must be ignored
    @(negedge clk); #1 bus.grant = 32'h1 << 1; bus.out_ready = 1'b0;
    @(negedge clk); #1 bus.grant = 32'h1 << 2;
    @(negedge clk);
    chk("bp_stall", 64'(bus.stall), 64'd1);
    chk("bp_main", 64'(bus.out_client), 64'd1);
    #1 bus.grant = 32'h1 << 3;
    @(negedge clk);
    chk("bp_hold_stall", 64'(bus.stall), 64'd1);
    chk("bp_hold_data", 64'(bus.out_data), 64'hA5A5_0001);
    #1 bus.grant = '0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_client", 64'(bus.out_client), 64'd2);
    chk("bp_drain_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Multi-hot grant selects lowest bit
    #1 bus.grant = 32'h0000_0030;
    @(negedge clk);
    chk("mh_client", 64'(bus.out_client), 64'd4);
    chk("mh_data", 64'(bus.out_data), 64'hA5A5_0004);
    chk("mh_err", 64'(bus.grant_err), 64'(CHK_EN));
    #1 bus.grant = '0;

    // Mixed directed burst with intermittent backpressure
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      bus.grant = (i % 3 == 2) ? '0 : (32'h1 << ((i * 7) % 32));
      if (i % 5 == 0) bus.grant = bus.grant | 32'h8000_0000;
      bus.out_ready = (i % 4 != 1);
    end

    // Reset mid-transfer discards held entries
    @(negedge clk); #1 bus.grant = 32'h1 << 4; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_stall", 64'(bus.stall), 64'd0);
    chk("mid_rst_client", 64'(bus.out_client), 64'd0);
    chk("mid_rst_err", 64'(bus.grant_err), 64'd0);
    @(negedge clk); #1 rst = 1'b0; bus.grant = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
